// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data-port responder: MMIO offsets, STATUS layout, FIFO sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package data_mem_pkg;

    // MMIO register offsets within the 16-byte window (byte offsets, addr[3:0]).
    localparam logic [3:0] OFF_GPIO    = 4'h0;
    localparam logic [3:0] OFF_CYCLE   = 4'h4;
    localparam logic [3:0] OFF_CONSOLE = 4'h8;
    localparam logic [3:0] OFF_STATUS  = 4'hC;

    // STATUS register bit positions.
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_CNT_LSB = 2;
    localparam int STAT_ERR     = 8;
    localparam int STAT_OVF     = 9;

    // Console transmit FIFO geometry.
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

    typedef struct packed {
        logic                  full;
        logic                  empty;
        logic [FIFO_CNT_W-1:0] count;
        logic                  err;
        logic                  ovf;
    } status_t;

    // Builds the 32-bit STATUS read value; unlisted bits read 0.
    function automatic logic [31:0] pack_status(input status_t s);
        logic [31:0] w;
        w = '0;
        w[STAT_FULL]                       = s.full;
        w[STAT_EMPTY]                      = s.empty;
        w[STAT_CNT_LSB +: FIFO_CNT_W]      = s.count;
        w[STAT_ERR]                        = s.err;
        w[STAT_OVF]                        = s.ovf;
        return w;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-port bus: byte address, store data/strobe, load strobe and load data.
// Latency: load data is combinational in the same cycle as mem_re.
// Backpressure: none; the responder accepts one access per cycle.
// Ports: master = CPU side (drives addr/wdata/we/re), slave = responder (drives rdata).
interface data_mem_responder_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_responder_console_fifo.sv
// Console transmit FIFO, 8 bits wide, 4 entries, synchronous push/pop.
// Latency: a pushed byte is visible at head one edge later.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
// Ports: clk, rst (async active-high), push/push_data, pop, head, count, full, empty.
module console_fifo
    import data_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty
);

    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [7:0]            mem_d [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full  = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    // Storage is reset so the head reads 0 out of reset.
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        // A simultaneous pop frees the slot, so a full FIFO can still accept.
        push_ok  = push & (~full | pop);
        pop_ok   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{(FIFO_CNT_W-1){1'b0}}, push_ok}
                          - {{(FIFO_CNT_W-1){1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: word RAM plus MMIO window (GPIO, cycle counter, console FIFO, STATUS).
// Latency: loads combinational (0 cycles); stores and side effects commit at the next edge.
// Backpressure: none on the CPU bus; console drains by valid/ready, overflow drops and flags.
// Ports: clk, rst (async active-high), bus (slave modport), cpu_halted, gpio_out,
//        console_valid/console_data/console_ready, err (sticky access error).
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_F000
)(
    input  logic                  clk,
    input  logic                  rst,
    data_mem_responder_if.slave   bus,
    input  logic                  cpu_halted,
    output logic [31:0]           gpio_out,
    output logic                  console_valid,
    output logic [7:0]            console_data,
    input  logic                  console_ready,
    output logic                  err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    // RAM contents are deliberately not reset.
    logic [31:0] ram [DEPTH_WORDS];

    logic [31:0] gpio_q, gpio_d;
    logic [31:0] cycle_q, cycle_d;
    logic        err_q, err_d;
    logic        ovf_q, ovf_d;

    logic        ram_hit, mmio_hit, misaligned, good, bad;
    logic        ram_we, mmio_we;
    logic [3:0]  off;
    logic [AW-1:0] ram_idx;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [7:0]  fifo_head;
    logic [31:0] rdata;
    status_t     status;

    // Address decode.
    always_comb begin
        ram_hit    = (bus.mem_addr < RAM_BYTES);
        mmio_hit   = (bus.mem_addr[31:4] == MMIO_BASE[31:4]);
        misaligned = (bus.mem_addr[1:0] != 2'b00);
        good       = ~misaligned & (ram_hit | mmio_hit);
        bad        = (bus.mem_we | bus.mem_re) & ~good;
        ram_we     = bus.mem_we & good & ram_hit;
        mmio_we    = bus.mem_we & good & mmio_hit;
        off        = bus.mem_addr[3:0];
        ram_idx    = bus.mem_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= bus.mem_wdata;
        end
    end

    assign fifo_push     = mmio_we & (off == OFF_CONSOLE);
    assign console_valid = ~fifo_empty;
    assign fifo_pop      = console_valid & console_ready;

    console_fifo u_console_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (bus.mem_wdata[7:0]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign console_data = fifo_head;

    always_comb begin
        status.full  = fifo_full;
        status.empty = fifo_empty;
        status.count = fifo_count;
        status.err   = err_q;
        status.ovf   = ovf_q;
    end

    // Register next-state. A status write and an error/overflow event cannot
    // coincide (one access per cycle), so set-after-clear ordering is harmless.
    always_comb begin
        gpio_d  = gpio_q;
        cycle_d = cpu_halted ? cycle_q : cycle_q + 32'd1;
        err_d   = err_q;
        ovf_d   = ovf_q;
        if (mmio_we) begin
            case (off)
                OFF_GPIO:   gpio_d  = bus.mem_wdata;
                OFF_CYCLE:  cycle_d = '0;
                OFF_STATUS: begin
                    if (bus.mem_wdata[STAT_ERR]) err_d = 1'b0;
                    if (bus.mem_wdata[STAT_OVF]) ovf_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (bad) begin
            err_d = 1'b1;
        end
        if (fifo_push & fifo_full & ~fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_q  <= '0;
            cycle_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            gpio_q  <= gpio_d;
            cycle_q <= cycle_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    // Load data reflects pre-edge state, so a load+store to one word returns the old value.
    always_comb begin
        rdata = '0;
        if (bus.mem_re && good) begin
            if (ram_hit) begin
                rdata = ram[ram_idx];
            end else begin
                case (off)
                    OFF_GPIO:   rdata = gpio_q;
                    OFF_CYCLE:  rdata = cycle_q;
                    OFF_STATUS: rdata = pack_status(status);
                    default:    rdata = '0;
                endcase
            end
        end
    end

    assign bus.mem_rdata = rdata;
    assign gpio_out      = gpio_q;
    assign err           = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        cpu_halted;
    logic [31:0] gpio_out;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        console_ready;
    logic        err;

    int checks;
    int errors;

    data_mem_responder_if bus();

    data_mem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .cpu_halted    (cpu_halted),
        .gpio_out      (gpio_out),
        .console_valid (console_valid),
        .console_data  (console_data),
        .console_ready (console_ready),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are then changed 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.mem_we    = 1'b1;
        bus.mem_re    = 1'b0;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        step();
        idle_bus();
    endtask

    task automatic present_load(input logic [31:0] a);
        bus.mem_we   = 1'b0;
        bus.mem_re   = 1'b1;
        bus.mem_addr = a;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio: got %h exp %h", gpio_out, 32'h0); end
        checks++;
        if (console_valid !== 1'b0 || console_data !== 8'h00) begin
            errors++; $display("FAIL reset_console: got v=%b d=%h exp v=0 d=00", console_valid, console_data);
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err); end
        checks++;
        if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", bus.mem_rdata); end
        present_load(32'h0000_F00C);
        checks++;
        if (bus.mem_rdata !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h exp %h", bus.mem_rdata, 32'h2); end
        idle_bus();
        step();
        rst = 1'b0;
    endtask

    task automatic test_ram();
        store(32'h10, 32'hDEAD_BEEF);
        present_load(32'h10);
        checks++;
        if (bus.mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd: got %h exp DEADBEEF", bus.mem_rdata); end
        bus.mem_re   = 1'b0;
        bus.mem_addr = 32'h14;
        #1;
        checks++;
        if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL ram_no_re: got %h exp 0", bus.mem_rdata); end
        idle_bus();
        store(32'h14, 32'h1234_5678);
        present_load(32'h14);
        checks++;
        if (bus.mem_rdata !== 32'h1234_5678) begin errors++; $display("FAIL ram_rd2: got %h exp 12345678", bus.mem_rdata); end
        // Simultaneous load+store: pre-write value now, new value after the edge.
        bus.mem_addr  = 32'h10;
        bus.mem_wdata = 32'hCAFE_F00D;
        bus.mem_we    = 1'b1;
        bus.mem_re    = 1'b1;
        #1;
        checks++;
        if (bus.mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rw_old: got %h exp DEADBEEF", bus.mem_rdata); end
        step();
        bus.mem_we = 1'b0;
        #1;
        checks++;
        if (bus.mem_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_rw_new: got %h exp CAFEF00D", bus.mem_rdata); end
        idle_bus();
    endtask

    task automatic test_misaligned();
        store(32'h13, 32'hFFFF_FFFF);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b exp 1", err); end
        present_load(32'h10);
        checks++;
        if (bus.mem_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis_ram: got %h exp CAFEF00D", bus.mem_rdata); end
        present_load(32'h0000_F00C);
        checks++;
        if (bus.mem_rdata !== 32'h0000_0102) begin errors++; $display("FAIL mis_status: got %h exp 00000102", bus.mem_rdata); end
        idle_bus();
        store(32'h0000_F00C, 32'h100);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b exp 0", err); end
    endtask

    task automatic test_gpio_mmio();
        store(32'h0000_F000, 32'hA5A5_0001);
        checks++;
        if (gpio_out !== 32'hA5A5_0001) begin errors++; $display("FAIL gpio_out: got %h exp A5A50001", gpio_out); end
        present_load(32'h0000_F000);
        checks++;
        if (bus.mem_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL gpio_rd: got %h exp A5A50001", bus.mem_rdata); end
        present_load(32'h0000_F008);
        checks++;
        if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL console_rd: got %h exp 0", bus.mem_rdata); end
        idle_bus();
    endtask

    task automatic test_cycle();
        cpu_halted = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        present_load(32'h0000_F004);
        checks++;
        if (bus.mem_rdata !== 32'd10) begin errors++; $display("FAIL cycle_10: got %0d exp 10", bus.mem_rdata); end
        // Clear in this same cycle; the write wins over the increment.
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = 32'h0000_1234;
        step();
        bus.mem_we = 1'b0;
        bus.mem_re = 1'b1;
        #1;
        checks++;
        if (bus.mem_rdata !== 32'd0) begin errors++; $display("FAIL cycle_clr: got %0d exp 0", bus.mem_rdata); end
        step();
        checks++;
        if (bus.mem_rdata !== 32'd1) begin errors++; $display("FAIL cycle_next: got %0d exp 1", bus.mem_rdata); end
        cpu_halted = 1'b1;
        repeat (5) step();
        checks++;
        if (bus.mem_rdata !== 32'd1) begin errors++; $display("FAIL cycle_halt: got %0d exp 1", bus.mem_rdata); end
        cpu_halted = 1'b0;
        step();
        checks++;
        if (bus.mem_rdata !== 32'd2) begin errors++; $display("FAIL cycle_resume: got %0d exp 2", bus.mem_rdata); end
        cpu_halted = 1'b1;
        idle_bus();
    endtask

    task automatic test_fifo_overflow();
        console_ready = 1'b0;
        checks++;
        if (console_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty_start: got %b exp 0", console_valid); end
        for (int i = 0; i < 5; i++) begin
            store(32'h0000_F008, 32'hFFFF_FF41 + 32'(i));
        end
        present_load(32'h0000_F00C);
        checks++;
        if (bus.mem_rdata !== 32'h0000_0211) begin errors++; $display("FAIL ovf_status: got %h exp 00000211", bus.mem_rdata); end
        idle_bus();
        console_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (console_valid !== 1'b1 || console_data !== 8'(8'h41 + i)) begin
                errors++; $display("FAIL drain_%0d: got v=%b d=%h exp v=1 d=%h", i, console_valid, console_data, 8'(8'h41 + i));
            end
            step();
        end
        checks++;
        if (console_valid !== 1'b0) begin errors++; $display("FAIL drain_done: got %b exp 0", console_valid); end
        console_ready = 1'b0;
        present_load(32'h0000_F00C);
        checks++;
        if (bus.mem_rdata !== 32'h0000_0202) begin errors++; $display("FAIL drained_status: got %h exp 00000202", bus.mem_rdata); end
        idle_bus();
        store(32'h0000_F00C, 32'h200);
        present_load(32'h0000_F00C);
        checks++;
        if (bus.mem_rdata !== 32'h0000_0002) begin errors++; $display("FAIL ovf_clear: got %h exp 00000002", bus.mem_rdata); end
        idle_bus();
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_b [4];
        exp_b = '{8'h51, 8'h52, 8'h53, 8'h55};
        console_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'h0000_F008, 32'h50 + 32'(i));
        end
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h0000_F008;
        bus.mem_wdata = 32'h55;
        console_ready = 1'b1;
        #1;
        checks++;
        if (console_data !== 8'h50) begin errors++; $display("FAIL fpp_head: got %h exp 50", console_data); end
        step();
        console_ready = 1'b0;
        present_load(32'h0000_F00C);
        checks++;
        if (bus.mem_rdata !== 32'h0000_0011) begin errors++; $display("FAIL fpp_status: got %h exp 00000011", bus.mem_rdata); end
        idle_bus();
        console_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (console_valid !== 1'b1 || console_data !== exp_b[i]) begin
                errors++; $display("FAIL fpp_drain_%0d: got v=%b d=%h exp v=1 d=%h", i, console_valid, console_data, exp_b[i]);
            end
            step();
        end
        checks++;
        if (console_valid !== 1'b0) begin errors++; $display("FAIL fpp_done: got %b exp 0", console_valid); end
        console_ready = 1'b0;
    endtask

    task automatic test_unmapped();
        present_load(32'h0000_8000);
        checks++;
        if (bus.mem_rdata !== 32'h0 || err !== 1'b0) begin
            errors++; $display("FAIL unmapped_rd: got rd=%h err=%b exp rd=0 err=0", bus.mem_rdata, err);
        end
        step();
        idle_bus();
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL unmapped_err: got %b exp 1", err); end
        store(32'h0000_F00C, 32'h100);
        store(32'h0000_0400, 32'h1);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL ram_edge_err: got %b exp 1", err); end
    endtask

    task automatic test_reset_mid_drain();
        store(32'h0000_F000, 32'h0000_00FF);
        console_ready = 1'b0;
        store(32'h0000_F008, 32'h61);
        store(32'h0000_F008, 32'h62);
        console_ready = 1'b1;
        step();
        checks++;
        if (console_valid !== 1'b1 || console_data !== 8'h62) begin
            errors++; $display("FAIL mid_drain: got v=%b d=%h exp v=1 d=62", console_valid, console_data);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (console_valid !== 1'b0 || console_data !== 8'h00 || gpio_out !== 32'h0 || err !== 1'b0) begin
            errors++; $display("FAIL rst_async: got v=%b d=%h gpio=%h err=%b exp 0 00 0 0", console_valid, console_data, gpio_out, err);
        end
        step();
        rst = 1'b0;
        console_ready = 1'b0;
        present_load(32'h10);
        checks++;
        if (bus.mem_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_keep: got %h exp CAFEF00D", bus.mem_rdata); end
        idle_bus();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cpu_halted    = 1'b1;
        console_ready = 1'b0;
        idle_bus();
        test_reset();
        test_ram();
        test_misaligned();
        test_gpio_mmio();
        test_cycle();
        test_fifo_overflow();
        test_full_push_pop();
        test_unmapped();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
